// File: rtl/hdr_classify.sv
// hdr_classify: ingress classification stage ahead of the action pipeline.
//
// Parses the SOP beat of each Avalon-ST packet, classifies it as IPv4, VLAN+IPv4, IPv6 or
// VLAN+IPv6, and issues one match-action lookup keyed on the destination address. The packet
// is buffered while the lookup is outstanding, then replayed with
// stream_out_tuser = {action, pkt_type}. Packets of unknown type are discarded and counted.
// Only one packet is in flight at a time.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   stream_in_*           Avalon-ST sink (stream_in_ready is an output)
//   stream_out_*          Avalon-ST source (stream_out_ready is an input)
//   stream_out_tuser      {action, pkt_type}, constant for the whole packet
//   lkp_req_*             lookup request (valid/ready handshake, key, packet type)
//   lkp_rsp_*             lookup response pulse (valid, hit, action); no backpressure
//   drop_count            saturating count of dropped packets
module hdr_classify #(
  parameter int unsigned DATA_WIDTH      = 600,
  parameter int unsigned EMPTY_WIDTH     = $clog2(DATA_WIDTH / 8),
  parameter int unsigned CHANNEL_WIDTH   = 6,
  parameter int unsigned ERROR_WIDTH     = 4,
  parameter int unsigned ACTN_DATA_WIDTH = 128,
  parameter int unsigned PT_WIDTH        = 4,
  parameter int unsigned KEY_WIDTH       = 128,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  // Input stream
  input  logic [DATA_WIDTH-1:0]               stream_in_data,
  input  logic [EMPTY_WIDTH-1:0]              stream_in_empty,
  input  logic                                stream_in_valid,
  output logic                                stream_in_ready,
  input  logic                                stream_in_startofpacket,
  input  logic                                stream_in_endofpacket,
  input  logic [CHANNEL_WIDTH-1:0]            stream_in_channel,
  input  logic [ERROR_WIDTH-1:0]              stream_in_error,
  // Output stream
  output logic [DATA_WIDTH-1:0]               stream_out_data,
  output logic [EMPTY_WIDTH-1:0]              stream_out_empty,
  output logic                                stream_out_valid,
  input  logic                                stream_out_ready,
  output logic                                stream_out_startofpacket,
  output logic                                stream_out_endofpacket,
  output logic [CHANNEL_WIDTH-1:0]            stream_out_channel,
  output logic [ERROR_WIDTH-1:0]              stream_out_error,
  output logic [ACTN_DATA_WIDTH+PT_WIDTH-1:0] stream_out_tuser,
  // Lookup interface
  output logic                                lkp_req_valid,
  input  logic                                lkp_req_ready,
  output logic [KEY_WIDTH-1:0]                lkp_req_key,
  output logic [PT_WIDTH-1:0]                 lkp_req_pt,
  input  logic                                lkp_rsp_valid,
  input  logic                                lkp_rsp_hit,
  input  logic [ACTN_DATA_WIDTH-1:0]          lkp_rsp_action,
  // Statistics
  output logic [31:0]                         drop_count
);

  localparam int unsigned D      = DATA_WIDTH;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned EntryW = DATA_WIDTH + EMPTY_WIDTH + CHANNEL_WIDTH + ERROR_WIDTH + 2;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StReq  = 3'd1;
  localparam logic [2:0] StWait = 3'd2;
  localparam logic [2:0] StFwd  = 3'd3;
  localparam logic [2:0] StDrop = 3'd4;

  localparam logic [15:0] EtIpv4 = 16'h0800;
  localparam logic [15:0] EtIpv6 = 16'h86DD;
  localparam logic [15:0] EtVlan = 16'h8100;

  // ---------------------------------------------------------------------------------------
  // SOP classification (combinational on the current input beat)
  // ---------------------------------------------------------------------------------------
  logic [15:0]          etype, inner_etype;
  logic                 cls_known;
  logic [PT_WIDTH-1:0]  cls_pt;
  logic [KEY_WIDTH-1:0] cls_key;

  assign etype       = stream_in_data[D-112 +: 16];
  assign inner_etype = stream_in_data[D-144 +: 16];

  always_comb begin
    cls_known = 1'b0;
    cls_pt    = '0;
    cls_key   = '0;
    if (etype == EtIpv4) begin
      cls_known = 1'b1;
      cls_pt    = PT_WIDTH'(1);
      cls_key   = KEY_WIDTH'(stream_in_data[D-272 +: 32]);
    end else if (etype == EtIpv6) begin
      cls_known = 1'b1;
      cls_pt    = PT_WIDTH'(3);
      cls_key   = KEY_WIDTH'(stream_in_data[D-432 +: 128]);
    end else if (etype == EtVlan) begin
      if (inner_etype == EtIpv4) begin
        cls_known = 1'b1;
        cls_pt    = PT_WIDTH'(2);
        cls_key   = KEY_WIDTH'(stream_in_data[D-304 +: 32]);
      end else if (inner_etype == EtIpv6) begin
        cls_known = 1'b1;
        cls_pt    = PT_WIDTH'(4);
        cls_key   = KEY_WIDTH'(stream_in_data[D-464 +: 128]);
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------
  logic [2:0]                 state_q, state_d;
  logic [KEY_WIDTH-1:0]       key_q, key_d;
  logic [PT_WIDTH-1:0]        pt_q, pt_d;
  logic [ACTN_DATA_WIDTH-1:0] action_q, action_d;
  logic                       eop_written_q, eop_written_d;
  logic [31:0]                drop_count_q, drop_count_d;
  // Holds stream_in_ready low while in reset and until the first clock after release.
  logic                       rst_done_q;

  logic [EntryW-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]     count_q;
  logic              fifo_full, fifo_empty;
  logic              wr_en, rd_en, drop_inc;
  logic              in_fire, out_fire;

  logic [DATA_WIDTH-1:0]    head_data;
  logic [EMPTY_WIDTH-1:0]   head_empty;
  logic [CHANNEL_WIDTH-1:0] head_channel;
  logic [ERROR_WIDTH-1:0]   head_error;
  logic                     head_sop, head_eop;

  assign fifo_full  = (count_q == (PtrW + 1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  assign {head_data, head_empty, head_channel, head_error, head_sop, head_eop} =
      mem_q[rd_ptr_q];

  always_comb begin
    if (state_q == StIdle || state_q == StDrop) begin
      stream_in_ready = rst_done_q;
    end else begin
      stream_in_ready = rst_done_q && !fifo_full && !eop_written_q;
    end
  end

  assign in_fire          = stream_in_valid && stream_in_ready;
  assign stream_out_valid = (state_q == StFwd) && !fifo_empty;
  assign out_fire         = stream_out_valid && stream_out_ready;
  assign rd_en            = out_fire;

  // ---------------------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    key_d         = key_q;
    pt_d          = pt_q;
    action_d      = action_q;
    eop_written_d = eop_written_q;
    wr_en         = 1'b0;
    drop_inc      = 1'b0;

    // Body beats of the in-flight packet are buffered in every state that owns a packet.
    if (state_q == StReq || state_q == StWait || state_q == StFwd) begin
      wr_en = in_fire;
      if (in_fire && stream_in_endofpacket) begin
        eop_written_d = 1'b1;
      end
    end

    case (state_q)
      StIdle: begin
        if (in_fire && stream_in_startofpacket) begin
          if (cls_known) begin
            wr_en         = 1'b1;
            key_d         = cls_key;
            pt_d          = cls_pt;
            action_d      = '0;
            eop_written_d = stream_in_endofpacket;
            state_d       = StReq;
          end else if (stream_in_endofpacket) begin
            drop_inc = 1'b1;
          end else begin
            state_d = StDrop;
          end
        end
      end
      StReq: begin
        if (lkp_req_ready) begin
          // A response in the same cycle as the request handshake is a zero-latency lookup.
          if (lkp_rsp_valid) begin
            action_d = lkp_rsp_hit ? lkp_rsp_action : '0;
            state_d  = StFwd;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (lkp_rsp_valid) begin
          action_d = lkp_rsp_hit ? lkp_rsp_action : '0;
          state_d  = StFwd;
        end
      end
      StFwd: begin
        if (out_fire && head_eop) begin
          eop_written_d = 1'b0;
          state_d       = StIdle;
        end
      end
      StDrop: begin
        if (in_fire && stream_in_endofpacket) begin
          drop_inc = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign drop_count_d = (drop_inc && (drop_count_q != '1)) ? drop_count_q + 32'd1
                                                           : drop_count_q;

  // ---------------------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      key_q         <= '0;
      pt_q          <= '0;
      action_q      <= '0;
      eop_written_q <= 1'b0;
      drop_count_q  <= '0;
      rst_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      key_q         <= key_d;
      pt_q          <= pt_d;
      action_q      <= action_d;
      eop_written_q <= eop_written_d;
      drop_count_q  <= drop_count_d;
      rst_done_q    <= 1'b1;
    end
  end

  // Storage is cleared on reset so the output fields read as zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= {stream_in_data, stream_in_empty, stream_in_channel, stream_in_error,
                          stream_in_startofpacket, stream_in_endofpacket};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (rd_en) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------
  assign stream_out_data          = head_data;
  assign stream_out_empty         = head_empty;
  assign stream_out_channel       = head_channel;
  assign stream_out_error         = head_error;
  assign stream_out_startofpacket = head_sop;
  assign stream_out_endofpacket   = head_eop;
  assign stream_out_tuser         = {action_q, pt_q};

  assign lkp_req_valid = (state_q == StReq);
  assign lkp_req_key   = key_q;
  assign lkp_req_pt    = pt_q;
  assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_hdr_classify.sv
// Directed, table-driven bench for hdr_classify.
module tb_hdr_classify;

  localparam int DW = 600;
  localparam int EW = $clog2(DW / 8);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] stream_in_data;
  logic [EW-1:0] stream_in_empty;
  logic          stream_in_valid, stream_in_ready;
  logic          stream_in_startofpacket, stream_in_endofpacket;
  logic [5:0]    stream_in_channel;
  logic [3:0]    stream_in_error;
  logic [DW-1:0] stream_out_data;
  logic [EW-1:0] stream_out_empty;
  logic          stream_out_valid, stream_out_ready;
  logic          stream_out_startofpacket, stream_out_endofpacket;
  logic [5:0]    stream_out_channel;
  logic [3:0]    stream_out_error;
  logic [131:0]  stream_out_tuser;
  logic          lkp_req_valid, lkp_req_ready;
  logic [127:0]  lkp_req_key;
  logic [3:0]    lkp_req_pt;
  logic          lkp_rsp_valid, lkp_rsp_hit;
  logic [127:0]  lkp_rsp_action;
  logic [31:0]   drop_count;

  always #5 clk = ~clk;

  hdr_classify dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .stream_in_data           (stream_in_data),
    .stream_in_empty          (stream_in_empty),
    .stream_in_valid          (stream_in_valid),
    .stream_in_ready          (stream_in_ready),
    .stream_in_startofpacket  (stream_in_startofpacket),
    .stream_in_endofpacket    (stream_in_endofpacket),
    .stream_in_channel        (stream_in_channel),
    .stream_in_error          (stream_in_error),
    .stream_out_data          (stream_out_data),
    .stream_out_empty         (stream_out_empty),
    .stream_out_valid         (stream_out_valid),
    .stream_out_ready         (stream_out_ready),
    .stream_out_startofpacket (stream_out_startofpacket),
    .stream_out_endofpacket   (stream_out_endofpacket),
    .stream_out_channel       (stream_out_channel),
    .stream_out_error         (stream_out_error),
    .stream_out_tuser         (stream_out_tuser),
    .lkp_req_valid            (lkp_req_valid),
    .lkp_req_ready            (lkp_req_ready),
    .lkp_req_key              (lkp_req_key),
    .lkp_req_pt               (lkp_req_pt),
    .lkp_rsp_valid            (lkp_rsp_valid),
    .lkp_rsp_hit              (lkp_rsp_hit),
    .lkp_rsp_action           (lkp_rsp_action),
    .drop_count               (drop_count)
  );

  typedef struct {
    logic [15:0]  et;
    logic [15:0]  inner;
    logic [127:0] addr;
    int           key_off;   // address placed at bit DW-key_off
    int           key_w;     // 0, 32 or 128
    int           n;         // beats
    bit           hit;
    logic [127:0] act;
    int           delay;     // cycles from request handshake to response
    bit           tog;       // toggle stream_out_ready
    logic [3:0]   exp_pt;
    logic [127:0] exp_key;
    bit           exp_drop;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [31:0] exp_drops;

  logic [DW-1:0] ed [16];
  logic [EW-1:0] ee [16];
  logic [5:0]    ec [16];
  logic [3:0]    er [16];
  int            sop_cyc, req_cyc, fv_cyc, stall_at, got;
  logic          rdy_at_eop;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] filler(input int seed);
    logic [DW-1:0] d;
    for (int b = 0; b < DW / 8; b++) d[b*8 +: 8] = 8'(seed * 37 + b * 11 + 5);
    return d;
  endfunction

  function automatic logic [DW-1:0] make_sop(input vec_t v);
    logic [DW-1:0] d;
    d = filler(101);
    d[DW-112 +: 16] = v.et;
    if (v.et == 16'h8100) d[DW-144 +: 16] = v.inner;
    if (v.key_w == 32) d[DW-v.key_off +: 32] = v.addr[31:0];
    else if (v.key_w == 128) d[DW-v.key_off +: 128] = v.addr;
    return d;
  endfunction

  task automatic run_pkt(input vec_t v, input string tag);
    int           bud;
    logic [131:0] exp_tuser;
    bud       = v.exp_drop ? 40 : 300;
    exp_tuser = {(v.hit ? v.act : 128'h0), v.exp_pt};
    for (int i = 0; i < v.n; i++) begin
      ed[i] = (i == 0) ? make_sop(v) : filler(i * 7 + int'(v.et[3:0]));
      ee[i] = (i == v.n - 1) ? EW'(i + 3) : '0;
      ec[i] = 6'(i + 1);
      er[i] = 4'(i);
    end
    sop_cyc = -1; req_cyc = -1; fv_cyc = -1; stall_at = -1; got = 0; rdy_at_eop = 1'b1;
    fork
      begin : drv
        int  b, g;
        bit  fire;
        b = 0; g = 0;
        while (b < v.n && g < bud) begin
          stream_in_valid         = 1'b1;
          stream_in_data          = ed[b];
          stream_in_empty         = ee[b];
          stream_in_channel       = ec[b];
          stream_in_error         = er[b];
          stream_in_startofpacket = (b == 0);
          stream_in_endofpacket   = (b == v.n - 1);
          fire = stream_in_ready;
          if (fire && b == 0) sop_cyc = cyc;
          if (!fire && stall_at < 0) stall_at = b;
          step();
          g++;
          if (fire) b++;
        end
        stream_in_valid = 1'b0;
        chk({tag, ".sent"}, b, v.n);
      end
      begin : rsp
        int g;
        bit seen;
        g = 0; seen = 0;
        if (v.exp_drop) begin
          while (g < bud) begin
            if (lkp_req_valid) seen = 1;
            step();
            g++;
          end
          chk({tag, ".noreq"}, seen, 0);
        end else begin
          while (!lkp_req_valid && g < bud) begin
            step();
            g++;
          end
          chk({tag, ".req_seen"}, lkp_req_valid, 1);
          if (lkp_req_valid) begin
            req_cyc = cyc;
            chk({tag, ".req_cyc"}, req_cyc - sop_cyc, 1);
            chk({tag, ".key"}, lkp_req_key, v.exp_key);
            chk({tag, ".pt"}, lkp_req_pt, v.exp_pt);
            lkp_req_ready  = 1'b1;
            lkp_rsp_hit    = v.hit;
            lkp_rsp_action = v.act;
            if (v.delay == 0) lkp_rsp_valid = 1'b1;
            step();
            lkp_req_ready = 1'b0;
            lkp_rsp_valid = 1'b0;
            if (v.delay > 0) begin
              repeat (v.delay - 1) step();
              lkp_rsp_valid = 1'b1;
              step();
              lkp_rsp_valid = 1'b0;
            end
          end
        end
      end
      begin : mon
        int g;
        bit done;
        g = 0; done = 0;
        while (!done && g < bud) begin
          stream_out_ready = v.tog ? (g % 2 == 0) : 1'b1;
          if (stream_out_valid && fv_cyc < 0) fv_cyc = cyc;
          if (stream_out_valid && stream_out_ready) begin
            if (got < 16) begin
              chk({tag, ".data"}, stream_out_data, ed[got]);
              chk({tag, ".side"},
                  {stream_out_startofpacket, stream_out_endofpacket, stream_out_empty,
                   stream_out_channel, stream_out_error},
                  {1'(got == 0), 1'(got == v.n - 1), ee[got], ec[got], er[got]});
              chk({tag, ".tuser"}, stream_out_tuser, exp_tuser);
            end
            if (stream_out_endofpacket) begin
              done       = 1;
              rdy_at_eop = stream_in_ready;
            end
            got++;
          end
          step();
          g++;
        end
        stream_out_ready = 1'b0;
      end
    join
    chk({tag, ".beats"}, got, v.exp_drop ? 0 : v.n);
    if (v.exp_drop && exp_drops != 32'hFFFF_FFFF) exp_drops = exp_drops + 1;
    chk({tag, ".drops"}, drop_count, exp_drops);
    if (v.delay == 0 && !v.exp_drop) chk({tag, ".latency"}, fv_cyc - sop_cyc, 2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    vec_t v;
    int   b, g;
    bit   fire, seen;

    tbl[0] = '{et: 16'h0800, inner: 16'h0, addr: 128'h0A00_0001, key_off: 272, key_w: 32,
               n: 1, hit: 1, act: 128'hA500_0000_0000_0000_0000_0000_0000_0001, delay: 0,
               tog: 0, exp_pt: 4'h1, exp_key: 128'h0A00_0001, exp_drop: 0};
    tbl[1] = '{et: 16'h8100, inner: 16'h86DD,
               addr: 128'h2001_0DB8_0000_0000_0000_0000_0000_0042, key_off: 464, key_w: 128,
               n: 3, hit: 0, act: 128'hDEAD_BEEF, delay: 3, tog: 0, exp_pt: 4'h4,
               exp_key: 128'h2001_0DB8_0000_0000_0000_0000_0000_0042, exp_drop: 0};
    tbl[2] = '{et: 16'h0806, inner: 16'h0, addr: 128'h0, key_off: 0, key_w: 0, n: 4, hit: 0,
               act: 128'h0, delay: 0, tog: 0, exp_pt: 4'h0, exp_key: 128'h0, exp_drop: 1};
    tbl[3] = '{et: 16'h0800, inner: 16'h0, addr: 128'hC0A8_0101, key_off: 272, key_w: 32,
               n: 2, hit: 1, act: 128'h1234_5678, delay: 1, tog: 0, exp_pt: 4'h1,
               exp_key: 128'hC0A8_0101, exp_drop: 0};
    tbl[4] = '{et: 16'h86DD, inner: 16'h0,
               addr: 128'hFE80_0000_0000_0000_0211_22FF_FE33_4455, key_off: 432, key_w: 128,
               n: 2, hit: 1, act: 128'hCAFE, delay: 5, tog: 1, exp_pt: 4'h3,
               exp_key: 128'hFE80_0000_0000_0000_0211_22FF_FE33_4455, exp_drop: 0};
    tbl[5] = '{et: 16'h8100, inner: 16'h0800, addr: 128'h0A0B_0C0D, key_off: 304, key_w: 32,
               n: 1, hit: 1, act: 128'h77, delay: 2, tog: 0, exp_pt: 4'h2,
               exp_key: 128'h0A0B_0C0D, exp_drop: 0};
    tbl[6] = '{et: 16'h8100, inner: 16'h0806, addr: 128'h0, key_off: 0, key_w: 0, n: 1,
               hit: 0, act: 128'h0, delay: 0, tog: 0, exp_pt: 4'h0, exp_key: 128'h0,
               exp_drop: 1};

    rst_n = 1'b0;
    stream_in_data = '0; stream_in_empty = '0; stream_in_valid = 1'b0;
    stream_in_startofpacket = 1'b0; stream_in_endofpacket = 1'b0;
    stream_in_channel = '0; stream_in_error = '0; stream_out_ready = 1'b0;
    lkp_req_ready = 1'b0; lkp_rsp_valid = 1'b0; lkp_rsp_hit = 1'b0; lkp_rsp_action = '0;
    exp_drops = '0;

    // Reset state
    repeat (2) step();
    chk("reset.flow", {stream_in_ready, stream_out_valid, lkp_req_valid}, 3'b000);
    chk("reset.drops", drop_count, 0);
    rst_n = 1'b1;
    step();
    chk("reset.rdy_after", stream_in_ready, 1);

    // Stray non-SOP beat in IDLE is swallowed silently
    stream_in_valid = 1'b1; stream_in_startofpacket = 1'b0; stream_in_endofpacket = 1'b1;
    stream_in_data = filler(9);
    chk("stray.rdy", stream_in_ready, 1);
    step();
    stream_in_valid = 1'b0;
    seen = 0;
    repeat (4) begin
      if (stream_out_valid || lkp_req_valid) seen = 1;
      step();
    end
    chk("stray.quiet", seen, 0);
    chk("stray.drops", drop_count, 0);

    for (int i = 0; i < 7; i++) run_pkt(tbl[i], $sformatf("v%0d", i));

    // Backpressure: FIFO fills while the lookup is slow, output drains at half rate
    v = tbl[3]; v.n = 12; v.delay = 20; v.tog = 1;
    run_pkt(v, "bp");
    chk("bp.stall_at", stall_at, 8);
    chk("bp.rdy_at_eop", rdy_at_eop, 0);
    chk("bp.rdy_next", stream_in_ready, 1);

    // Reset while waiting on the lookup with 5 beats buffered
    v = tbl[3]; v.n = 8;
    b = 0; g = 0;
    while (b < 5 && g < 50) begin
      stream_in_valid         = 1'b1;
      stream_in_data          = (b == 0) ? make_sop(v) : filler(b + 50);
      stream_in_startofpacket = (b == 0);
      stream_in_endofpacket   = 1'b0;
      lkp_req_ready           = lkp_req_valid;
      fire = stream_in_ready;
      step();
      g++;
      if (fire) b++;
    end
    stream_in_valid = 1'b0;
    repeat (3) begin
      lkp_req_ready = lkp_req_valid;
      step();
    end
    lkp_req_ready = 1'b0;
    chk("rst.pre_key", lkp_req_key, 128'hC0A8_0101);
    chk("rst.pre_flow", {stream_in_ready, stream_out_valid, lkp_req_valid}, 3'b100);
    rst_n = 1'b0;
    #1;
    chk("rst.flow", {stream_in_ready, stream_out_valid, lkp_req_valid}, 3'b000);
    chk("rst.data", stream_out_data, 0);
    chk("rst.side", {stream_out_startofpacket, stream_out_endofpacket, stream_out_empty,
                     stream_out_channel, stream_out_error}, 0);
    chk("rst.tuser", stream_out_tuser, 0);
    chk("rst.key_pt", {lkp_req_key, lkp_req_pt}, 0);
    chk("rst.drops", drop_count, 0);
    exp_drops = '0;
    repeat (2) step();
    rst_n = 1'b1;
    chk("rst.rdy_held", stream_in_ready, 0);
    step();
    chk("rst.rdy_after", stream_in_ready, 1);
    lkp_rsp_valid = 1'b1; lkp_rsp_hit = 1'b1; lkp_rsp_action = 128'hBAD;
    step();
    lkp_rsp_valid = 1'b0;
    seen = 0;
    repeat (6) begin
      if (stream_out_valid || lkp_req_valid) seen = 1;
      step();
    end
    chk("rst.no_stale", seen, 0);
    run_pkt(tbl[0], "rst.fresh");

    // Saturation of the drop counter
    force dut.drop_count_q = 32'hFFFF_FFFF;
    step();
    release dut.drop_count_q;
    step();
    exp_drops = 32'hFFFF_FFFF;
    chk("sat.preset", drop_count, 32'hFFFF_FFFF);
    run_pkt(tbl[2], "sat");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
